// File: rtl/brq_ldst_pkg.sv
// Shared types and lane-code constants for the data-memory load/store sequencer.
package brq_ldst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LD_WAIT   = 2'd1,
        ST_RMW_MERGE = 2'd2,
        ST_DONE      = 2'd3
    } ldst_state_e;

    localparam logic [2:0] LANE_B0  = 3'b000;
    localparam logic [2:0] LANE_B1  = 3'b001;
    localparam logic [2:0] LANE_B2  = 3'b010;
    localparam logic [2:0] LANE_B3  = 3'b011;
    localparam logic [2:0] LANE_HLO = 3'b100;
    localparam logic [2:0] LANE_HHI = 3'b101;
    localparam logic [2:0] LANE_W   = 3'b110;
    localparam logic [2:0] LANE_ILL = 3'b111;

endpackage

// File: rtl/rmw_merge.sv
// Replaces one byte/half/word lane of an old word with right-aligned new data.
module rmw_merge
    import brq_ldst_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] old_word_i,
    input  logic [DataWidth-1:0] new_data_i,
    input  logic [2:0]           lane_i,
    output logic [DataWidth-1:0] merged_o
);

    // Lane substitution; unknown codes leave the old word intact
    always_comb begin
        merged_o = old_word_i;
        case (lane_i)
            LANE_B0:  merged_o[7:0]   = new_data_i[7:0];
            LANE_B1:  merged_o[15:8]  = new_data_i[7:0];
            LANE_B2:  merged_o[23:16] = new_data_i[7:0];
            LANE_B3:  merged_o[31:24] = new_data_i[7:0];
            LANE_HLO: merged_o[15:0]  = new_data_i[15:0];
            LANE_HHI: merged_o[31:16] = new_data_i[15:0];
            LANE_W:   merged_o        = new_data_i;
            default:  merged_o        = old_word_i;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data BRAM sequencer: single-cycle word stores, read-modify-write sub-word
// stores, registered raw load word, and the core stall request.
module dmem_rmw_ctrl
    import brq_ldst_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_n,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_byte_en,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 dmem_en,
    output logic                 dmem_we,
    output logic [AddrWidth-1:0] dmem_addr,
    output logic [DataWidth-1:0] dmem_wdata,
    input  logic [DataWidth-1:0] dmem_rdata,
    output logic                 load_valid,
    output logic [DataWidth-1:0] load_data,
    output logic                 misalign_err,
    output logic                 ldst_stall
);

    ldst_state_e          state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [2:0]           lane_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 we_q;
    logic [DataWidth-1:0] load_data_q;

    logic                 accept_s;
    logic                 en_s, we_s, stall_s, misalign_s;
    logic [AddrWidth-1:0] addr_s;
    logic [DataWidth-1:0] wdata_s;
    logic [DataWidth-1:0] merged_s;

    rmw_merge #(.DataWidth(DataWidth)) u_merge (
        .old_word_i (dmem_rdata),
        .new_data_i (wdata_q),
        .lane_i     (lane_q),
        .merged_o   (merged_s)
    );

    // Next-state and BRAM/stall decode
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        en_s       = 1'b0;
        we_s       = 1'b0;
        addr_s     = '0;
        wdata_s    = '0;
        stall_s    = 1'b0;
        misalign_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_byte_en == LANE_ILL) begin
                        misalign_s = 1'b1;
                    end else if (req_we && (req_byte_en == LANE_W)) begin
                        en_s    = 1'b1;
                        we_s    = 1'b1;
                        addr_s  = req_addr;
                        wdata_s = req_wdata;
                    end else begin
                        en_s    = 1'b1;
                        addr_s  = req_addr;
                        stall_s = 1'b1;
                        state_d = req_we ? ST_RMW_MERGE : ST_LD_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LD_WAIT: begin
                stall_s = 1'b1;
                state_d = ST_DONE;
            end
            ST_RMW_MERGE: begin
                en_s    = 1'b1;
                we_s    = 1'b1;
                addr_s  = addr_q;
                wdata_s = merged_s;
                stall_s = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered load word
    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            lane_q      <= 3'b000;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                addr_q  <= req_addr;
                lane_q  <= req_byte_en;
                wdata_q <= req_wdata;
                we_q    <= req_we;
            end
            if (state_q == ST_LD_WAIT) begin
                load_data_q <= dmem_rdata;
            end
        end
    end

    // Strobes are gated by reset so an in-flight RMW write dies the moment reset asserts
    assign dmem_en      = en_s & brq_rst_n;
    assign dmem_we      = we_s & brq_rst_n;
    assign dmem_addr    = addr_s;
    assign dmem_wdata   = wdata_s;
    assign ldst_stall   = stall_s & brq_rst_n;
    assign misalign_err = misalign_s & brq_rst_n;
    assign load_valid   = (state_q == ST_DONE) & ~we_q & brq_rst_n;
    assign load_data    = load_data_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboarded bench: stimulus pushes expected BRAM writes and load words,
// a free-running monitor pops and compares them as the DUT presents them.
module tb_dmem_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_byte_en;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        dmem_en, dmem_we;
    logic [14:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        ldst_stall;

    logic [31:0] mem [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = 15'd0;
    logic [31:0] pre_data = 32'd0;

    logic [46:0] wr_q [$];
    logic [31:0] ld_q [$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(.DataWidth(32), .AddrWidth(15)) dut (
        .brq_clk      (clk),
        .brq_rst_n    (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_byte_en  (req_byte_en),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .dmem_en      (dmem_en),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .ldst_stall   (ldst_stall)
    );

    // Word-wide BRAM, 1-cycle read latency, plus a bench preload port
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (dmem_en) begin
            if (dmem_we) mem[dmem_addr] <= dmem_wdata;
            else dmem_rdata <= mem[dmem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_byte_en = 3'b000;
        req_addr = 15'd0; req_wdata = 32'd0;
    endtask

    // Present a request, count stalled cycles, and check load_valid on the release cycle
    task automatic do_req(input logic we, input logic [2:0] code, input logic [14:0] a,
                          input logic [31:0] wd, input int exp_stall, input bit scramble);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_byte_en = code; req_addr = a; req_wdata = wd;
        n = 0;
        #1;
        while (ldst_stall && n < 8) begin
            n++;
            @(negedge clk);
            if (scramble) begin
                req_addr = 15'h7FF; req_wdata = 32'hFFFF_FFFF;
            end
            #1;
        end
        check("stall_cycles", n, exp_stall);
        check("load_valid_release", {31'd0, load_valid}, {31'd0, (!we && code != 3'b111)});
    endtask

    // Monitor: compare every BRAM write and every load_valid against the scoreboard
    initial begin
        logic [46:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (dmem_en && dmem_we) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", dmem_addr, dmem_wdata);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {17'd0, dmem_addr}, {17'd0, e[46:32]});
                    check("wr_data", dmem_wdata, e[31:0]);
                end
            end
            if (load_valid) begin
                if (ld_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_load: got %h expected none", load_data);
                end else begin
                    check("load_data", load_data, ld_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_byte_en = 3'b110;
        req_addr = 15'h010; req_wdata = 32'h1234_5678;
        #1;
        check("rst_dmem_en", {31'd0, dmem_en}, 32'd0);
        check("rst_stall", {31'd0, ldst_stall}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        req_valid = 1'b0;
        preload(15'h020, 32'h1122_3344);
        preload(15'h040, 32'h1122_3344);
        preload(15'h030, 32'h5566_7788);
        preload(15'h050, 32'hA5A5_A5A5);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store, then load of the same word
        wr_q.push_back({15'h010, 32'hDEAD_BEEF});
        do_req(1'b1, 3'b110, 15'h010, 32'hDEAD_BEEF, 0, 1'b0);
        ld_q.push_back(32'hDEAD_BEEF);
        do_req(1'b0, 3'b110, 15'h010, 32'h0, 2, 1'b0);

        // Byte store to lane 2 with request inputs changed while busy
        wr_q.push_back({15'h020, 32'h11AB_3344});
        do_req(1'b1, 3'b010, 15'h020, 32'h0000_00AB, 2, 1'b1);

        // Half stores
        wr_q.push_back({15'h040, 32'hCAFE_3344});
        do_req(1'b1, 3'b101, 15'h040, 32'h0000_CAFE, 2, 1'b0);
        wr_q.push_back({15'h040, 32'hCAFE_BEEF});
        do_req(1'b1, 3'b100, 15'h040, 32'h0000_BEEF, 2, 1'b0);

        // Illegal lane code
        do_req(1'b1, 3'b111, 15'h040, 32'h1234_5678, 0, 1'b0);
        check("ill_misalign", {31'd0, misalign_err}, 32'd1);
        check("ill_dmem_en", {31'd0, dmem_en}, 32'd0);
        idle();
        #1;
        check("ill_misalign_drop", {31'd0, misalign_err}, 32'd0);
        check("ill_mem_unchanged", mem[15'h040], 32'hCAFE_BEEF);

        // Back-to-back byte stores then loads
        wr_q.push_back({15'h030, 32'h5566_7712});
        do_req(1'b1, 3'b000, 15'h030, 32'h0000_0012, 2, 1'b0);
        wr_q.push_back({15'h030, 32'h9A66_7712});
        do_req(1'b1, 3'b011, 15'h030, 32'h0000_009A, 2, 1'b0);
        ld_q.push_back(32'h9A66_7712);
        do_req(1'b0, 3'b000, 15'h030, 32'h0, 2, 1'b0);
        ld_q.push_back(32'h11AB_3344);
        do_req(1'b0, 3'b101, 15'h020, 32'h0, 2, 1'b0);

        // Reset asserted during the RMW write cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte_en = 3'b001;
        req_addr = 15'h050; req_wdata = 32'h0000_003C;
        #1;
        check("rmw_read_stall", {31'd0, ldst_stall}, 32'd1);
        @(negedge clk);
        #1;
        check("rmw_we", {31'd0, dmem_we}, 32'd1);
        check("rmw_wdata", dmem_wdata, 32'hA5A5_3CA5);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_rmw_we", {31'd0, dmem_we}, 32'd0);
        check("rst_rmw_en", {31'd0, dmem_en}, 32'd0);
        check("rst_rmw_stall", {31'd0, ldst_stall}, 32'd0);
        @(negedge clk);
        check("rst_rmw_load_data", load_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rmw_mem", mem[15'h050], 32'hA5A5_A5A5);
        ld_q.push_back(32'hA5A5_A5A5);
        do_req(1'b0, 3'b110, 15'h050, 32'h0, 2, 1'b0);

        idle();
        repeat (4) @(negedge clk);
        check("wr_q_drained", wr_q.size(), 32'd0);
        check("ld_q_drained", ld_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
